// File: rtl/dec_pkg.sv
// Shared types and constants for the registered binary-to-vector decoder.
// Optional out-of-range counter is enabled with DEC_OOR_CNT_EN.
package dec_pkg;

  localparam logic DEC_MODE_ONEHOT = 1'b0;
  localparam logic DEC_MODE_THERMO = 1'b1;

  localparam int unsigned DEC_OOR_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Width wide enough to hold both the code and OUT_WIDTH itself, so the range compare never wraps.
  function automatic int unsigned dec_cmp_w(input int unsigned in_w, input int unsigned out_w);
    int unsigned need;
    need = 32'($clog2(out_w)) + 32'd1;
    return (in_w > need) ? in_w : need;
  endfunction

endpackage

// File: rtl/dec_pipe_if.sv
// Valid/ready handshake bundle for dec_pipe: code beat in, decoded vector out.
interface dec_pipe_if #(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 1 << IN_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_code;
  logic                 in_en;
  logic                 in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_vec;
  logic                 out_oor;

  modport master (
    output in_valid, in_code, in_en, in_mode, out_ready,
    input  in_ready, out_valid, out_vec, out_oor
  );

  modport slave (
    input  in_valid, in_code, in_en, in_mode, out_ready,
    output in_ready, out_valid, out_vec, out_oor
  );

endinterface

// File: rtl/dec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; in_ready and out_valid are register outputs.
module dec_skid_buf
  import dec_pkg::*;
#(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_e         state;
  occ_e         state_nxt;
  logic         ready_q;
  logic         valid_q;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;
  logic         main_ld;
  logic         skid_ld;
  logic         main_from_skid;

  assign in_fire  = in_valid & ready_q;
  assign out_fire = valid_q & out_ready;

  // Occupancy register; handshake flags are precomputed from the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != TWO);
      valid_q <= (state_nxt != EMPTY);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (in_fire) state_nxt = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_nxt = TWO;
        else if (!in_fire && out_fire) state_nxt = EMPTY;
      end
      TWO:     if (out_fire) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: main_ld = in_fire;
      ONE: begin
        main_ld = in_fire & out_fire;
        skid_ld = in_fire & ~out_fire;
      end
      TWO: begin
        main_ld        = out_fire;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld) main_q <= main_from_skid ? skid_q : in_data;
      if (skid_ld) skid_q <= in_data;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/dec_pipe.sv
// Registered one-hot/thermometer decoder with out-of-range flag behind a skid buffer.
// Define DEC_OOR_CNT_EN to add the saturating oor_count port.
module dec_pipe
  import dec_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 1 << IN_WIDTH
) (
  input  logic clk,
  input  logic rst,
  dec_pipe_if.slave bus
`ifdef DEC_OOR_CNT_EN
  ,
  output logic [DEC_OOR_CNT_W-1:0] oor_count
`endif
);

  localparam int unsigned CMP_W = dec_cmp_w(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned PAY_W = OUT_WIDTH + 1;

  logic [CMP_W-1:0]     code_ext;
  logic [OUT_WIDTH-1:0] vec_c;
  logic                 oor_c;
  logic [PAY_W-1:0]     pay_q;

  // Decode ahead of the buffer; out-of-range saturates to zeros (one-hot) or ones (thermometer).
  always_comb begin
    code_ext = CMP_W'(bus.in_code);
    oor_c    = bus.in_en && (code_ext >= CMP_W'(OUT_WIDTH));
    vec_c    = '0;
    if (bus.in_en) begin
      if (oor_c) begin
        vec_c = (bus.in_mode == DEC_MODE_THERMO) ? '1 : '0;
      end else begin
        for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
          vec_c[i] = (bus.in_mode == DEC_MODE_THERMO) ? (CMP_W'(i) <= code_ext)
                                                      : (CMP_W'(i) == code_ext);
        end
      end
    end
  end

  dec_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   ({oor_c, vec_c}),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (pay_q)
  );

  assign bus.out_vec = pay_q[OUT_WIDTH-1:0];
  assign bus.out_oor = pay_q[OUT_WIDTH];

`ifdef DEC_OOR_CNT_EN
  logic [DEC_OOR_CNT_W-1:0] cnt_q;

  // Counted on acceptance so stalled beats are not missed or double counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.in_valid && bus.in_ready && oor_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + DEC_OOR_CNT_W'(1);
    end
  end

  assign oor_count = cnt_q;
`else
  // Without the counter, out_oor alone reports range errors.
`endif

endmodule

// File: tb/tb_dec_pipe.sv
// Self-checking bench for dec_pipe: 16-wide and 10-wide instances against a reference model.
module tb_dec_pipe;

  logic clk = 1'b0;
  logic rst;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  dec_pipe_if #(.IN_WIDTH(4), .OUT_WIDTH(16)) a ();
  dec_pipe_if #(.IN_WIDTH(4), .OUT_WIDTH(10)) b ();

`ifdef DEC_OOR_CNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  dec_pipe #(.IN_WIDTH(4), .OUT_WIDTH(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
`ifdef DEC_OOR_CNT_EN
    , .oor_count (cnt_a)
`endif
  );

  dec_pipe #(.IN_WIDTH(4), .OUT_WIDTH(10)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
`ifdef DEC_OOR_CNT_EN
    , .oor_count (cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit sel, input bit v, input int code, input bit en,
                        input bit mode, input bit ordy);
    if (!sel) begin
      a.in_valid = v; a.in_code = 4'(code); a.in_en = en; a.in_mode = mode; a.out_ready = ordy;
    end else begin
      b.in_valid = v; b.in_code = 4'(code); b.in_en = en; b.in_mode = mode; b.out_ready = ordy;
    end
  endtask

  function automatic logic [31:0] o_vec(input bit sel);
    return sel ? 32'(b.out_vec) : 32'(a.out_vec);
  endfunction
  function automatic logic [31:0] o_oor(input bit sel);
    return sel ? 32'(b.out_oor) : 32'(a.out_oor);
  endfunction
  function automatic logic [31:0] o_valid(input bit sel);
    return sel ? 32'(b.out_valid) : 32'(a.out_valid);
  endfunction
  function automatic logic [31:0] o_ready(input bit sel);
    return sel ? 32'(b.in_ready) : 32'(a.in_ready);
  endfunction

  // Reference decode: {oor, vec} computed from the rules with plain arithmetic.
  function automatic logic [16:0] model(input int code, input bit en, input bit mode, input int ow);
    if (!en) return 17'h0;
    if (code >= ow) return mode ? {1'b1, 16'((1 << ow) - 1)} : 17'h10000;
    return mode ? {1'b0, 16'((2 << code) - 1)} : {1'b0, 16'(1 << code)};
  endfunction

  task automatic single(input bit sel, input string tag, input int code, input bit en,
                        input bit mode, input logic [15:0] ev, input bit eo);
    chk({tag, "_rdy"}, o_ready(sel), 32'd1);
    set_in(sel, 1'b1, code, en, mode, 1'b1);
    tick();
    set_in(sel, 1'b0, code, en, mode, 1'b1);
    chk({tag, "_valid"}, o_valid(sel), 32'd1);
    chk({tag, "_vec"}, o_vec(sel), 32'(ev));
    chk({tag, "_oor"}, o_oor(sel), 32'(eo));
    tick();
    chk({tag, "_drain"}, o_valid(sel), 32'd0);
  endtask

  // Random traffic scoreboarded against model; bp=0 holds in_valid/out_ready high.
  task automatic run_rand(input bit sel, input int n, input bit bp, input int ow);
    logic [16:0] q[$];
    logic [16:0] e;
    int code;
    int nout;
    bit en, mode, v, r;
    nout = 0;
    for (int c = 0; c < n + 12; c++) begin
      v    = (c < n) && (bp ? ($urandom_range(0, 3) != 0) : 1'b1);
      r    = (c >= n) || (bp ? ($urandom_range(0, 2) != 0) : 1'b1);
      code = int'($urandom_range(0, 15));
      en   = ($urandom_range(0, 7) != 0);
      mode = 1'($urandom_range(0, 1));
      set_in(sel, v, code, en, mode, r);
      if (!bp && c >= 1 && c <= n) chk("stream_valid", o_valid(sel), 32'd1);
      if (o_valid(sel) == 32'd1 && r) begin
        e = (q.size() > 0) ? q.pop_front() : 17'bx;
        chk("rand_vec", o_vec(sel), 32'(e[15:0]));
        chk("rand_oor", o_oor(sel), 32'(e[16]));
        nout++;
      end
      if (v && o_ready(sel) == 32'd1) q.push_back(model(code, en, mode, ow));
      tick();
    end
    chk("rand_left", 32'(q.size()), 32'd0);
    if (!bp) chk("stream_count", 32'(nout), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_valid", o_valid(1'b0), 32'd0);
    chk("rst_ready", o_ready(1'b0), 32'd0);
    chk("rst_vec", o_vec(1'b0), 32'd0);
    chk("rst_oor", o_oor(1'b0), 32'd0);
`ifdef DEC_OOR_CNT_EN
    chk("rst_cnt", 32'(cnt_a), 32'd0);
`endif
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", o_ready(1'b0), 32'd1);

    single(1'b0, "oh5", 5, 1'b1, 1'b0, 16'h0020, 1'b0);
    single(1'b0, "th3", 3, 1'b1, 1'b1, 16'h000F, 1'b0);
    single(1'b0, "th15", 15, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    single(1'b0, "en0", 9, 1'b0, 1'b1, 16'h0000, 1'b0);
    single(1'b1, "oor_oh12", 12, 1'b1, 1'b0, 16'h0000, 1'b1);
    single(1'b1, "oor_th12", 12, 1'b1, 1'b1, 16'h03FF, 1'b1);
`ifdef DEC_OOR_CNT_EN
    chk("cnt_b", 32'(cnt_b), 32'd2);
    chk("cnt_a", 32'(cnt_a), 32'd0);
`endif

    // Backpressure: codes 1,2,3 one-hot with out_ready low.
    set_in(1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_rdy1", o_ready(1'b0), 32'd1);
    chk("bp_vec1", o_vec(1'b0), 32'h2);
    set_in(1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_rdy2", o_ready(1'b0), 32'd0);
    chk("bp_hold1", o_vec(1'b0), 32'h2);
    set_in(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("bp_stall", o_ready(1'b0), 32'd0);
    chk("bp_hold2", o_vec(1'b0), 32'h2);
    chk("bp_hold_valid", o_valid(1'b0), 32'd1);
    set_in(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1);
    tick();
    chk("bp_vec2", o_vec(1'b0), 32'h4);
    chk("bp_rdy3", o_ready(1'b0), 32'd1);
    tick();
    set_in(1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1);
    chk("bp_vec3", o_vec(1'b0), 32'h8);
    tick();
    chk("bp_empty", o_valid(1'b0), 32'd0);

    run_rand(1'b0, 20, 1'b0, 16);
    run_rand(1'b1, 60, 1'b1, 10);

    // Fill to two entries, then reset mid-cycle.
    set_in(1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 1'b1, 13, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 1'b1, 14, 1'b1, 1'b0, 1'b0);
    tick();
    chk("two_rdy", o_ready(1'b0), 32'd0);
    chk("two_rdy_b", o_ready(1'b1), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", o_valid(1'b0), 32'd0);
    chk("mid_rst_vec", o_vec(1'b0), 32'd0);
    chk("mid_rst_valid_b", o_valid(1'b1), 32'd0);
`ifdef DEC_OOR_CNT_EN
    chk("mid_rst_cnt_b", 32'(cnt_b), 32'd0);
`endif
    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    single(1'b0, "post_rst_th4", 4, 1'b1, 1'b1, 16'h001F, 1'b0);
    single(1'b1, "post_rst_oh9", 9, 1'b1, 1'b0, 16'h0200, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
